// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback (P) vs long-latency writeback (L),
// with an anti-starvation wait counter, a busy scoreboard for ID, and a registered write stage.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  output logic        p_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  output logic        l_ready,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  chk_addr_1,
  input  logic [4:0]  chk_addr_2,
  output logic        busy_1,
  output logic        busy_2,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_busy;
  logic             r_wen_p1;
  logic [4:0]       r_waddr_p1;
  logic [31:0]      r_wdata_p1;

  logic             w_l_win;
  logic             w_wr_go;
  logic [4:0]       w_wr_addr;
  logic [31:0]      w_wr_data;
  logic [31:0]      w_busy_nxt;

  // Stage p0: arbitration; L only beats P once it has waited MAX_WAIT cycles
  always_comb begin
    w_l_win = l_valid && (!p_valid || (r_wait_cnt == MAX_CNT));
    l_ready = !rst && w_l_win;
    p_ready = !rst && p_valid && !w_l_win;
  end

  always_comb begin
    w_wr_addr = l_ready ? l_addr : p_addr;
    w_wr_data = l_ready ? l_data : p_data;
    w_wr_go   = (p_ready || l_ready) && (w_wr_addr != 5'd0);
  end

  // Issue is applied after the L clear so a same-address collision stays busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (l_ready)
      w_busy_nxt[l_addr] = 1'b0;
    if (issue_en && (issue_addr != 5'd0))
      w_busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_wait_cnt <= '0;
    else if (!l_valid || l_ready)
      r_wait_cnt <= '0;
    else if (r_wait_cnt != MAX_CNT)
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen_p1   <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
    end else begin
      r_wen_p1 <= w_wr_go;
      if (w_wr_go) begin
        r_waddr_p1 <= w_wr_addr;
        r_wdata_p1 <= w_wr_data;
      end
    end
  end

  assign busy_1     = !rst && (chk_addr_1 != 5'd0) && r_busy[chk_addr_1];
  assign busy_2     = !rst && (chk_addr_2 != 5'd0) && r_busy[chk_addr_2];
  assign write_en   = r_wen_p1;
  assign write_addr = r_waddr_p1;
  assign write_data = r_wdata_p1;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two producers.
  - The in-order pipeline writeback stage (P).
  - The long-latency unit writeback, e.g. the multiply/divide result (L).
- Keeps a 32-bit busy scoreboard of destination registers with an outstanding L result. ID uses it for stall decisions.
- Drives the register file's write_en/write_addr/write_data from a registered output stage.

Parameters:
- MAX_WAIT, 4, consecutive cycles L may wait while P wins before L is force-granted (1..15).
- CNT_W, 4, width of the L wait counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- p_valid  input  1  pipeline writeback request
- p_addr  input  5  pipeline destination register
- p_data  input  32  pipeline result
- p_ready  output  1  pipeline request accepted this cycle (combinational)
- l_valid  input  1  long-latency writeback request; held with stable addr/data until accepted
- l_addr  input  5  long-latency destination register
- l_data  input  32  long-latency result
- l_ready  output  1  long-latency request accepted this cycle (combinational)
- issue_en  input  1  long-latency op issued; mark issue_addr busy
- issue_addr  input  5  destination of issued long-latency op
- chk_addr_1  input  5  ID source register 1 to check
- chk_addr_2  input  5  ID source register 2 to check
- busy_1  output  1  chk_addr_1 has an outstanding L write (combinational)
- busy_2  output  1  chk_addr_2 has an outstanding L write (combinational)
- write_en  output  1  register file write enable (registered)
- write_addr  output  5  register file write address (registered)
- write_data  output  32  register file write data (registered)

Behaviour:
- Reset (rst=1 at posedge clk):
  - write_en=0, write_addr=0, write_data=0.
  - busy scoreboard=0 and wait counter=0.
  - Any in-flight request or grant is dropped.
  - While rst=1, p_ready=0, l_ready=0, busy_1=0, busy_2=0.
- Arbitration, evaluated combinationally each cycle:
  - Only p_valid: p_ready=1.
  - Only l_valid: l_ready=1.
  - Both valid, wait counter < MAX_WAIT: P wins, l_ready=0.
  - Both valid, wait counter == MAX_WAIT: L wins, p_ready=0.
  - Neither valid: both ready=0.
  - At most one ready is high per cycle.
- Wait counter:
  - Increments each cycle l_valid=1 and l_ready=0, saturating at MAX_WAIT.
  - Clears on an L grant or when l_valid=0.
- Latency: a request granted in cycle N produces write_en=1 with its addr/data in cycle N+1. The register file's same-cycle bypass covers the gap.
- No grant in cycle N: write_en=0 in N+1. write_addr/write_data hold their last values.
- Register 0: a grant with addr 0 is accepted (ready=1) but write_en stays 0 in N+1.
- Scoreboard:
  - issue_en=1 with issue_addr!=0 sets busy[issue_addr] at the next edge.
  - An L grant clears busy[l_addr] at the next edge.
  - Set and clear on the same address in the same cycle: set wins (new op issued).
  - Issue to an already-busy register: bit stays set.
  - issue_addr=0 is ignored.
- busy_k = busy[chk_addr_k], with chk_addr_k=0 always reporting 0. This is a pure read with no bypass: a clear in cycle N is visible in N+1.
- P grants never modify the scoreboard. P writing a busy register is permitted; WAW ordering is ID's responsibility.
- L protocol: l_valid stays high with stable l_addr/l_data until l_ready. If l_valid drops without a grant, the counter clears and no write occurs.

Test Plan:
1. Reset, then P only: p_valid=1, p_addr=5, p_data=0x12345678 at cycle N → p_ready=1 at N; write_en=1, write_addr=5, write_data=0x12345678 at N+1; write_en=0 at N+2.
2. Starvation: issue_en to addr 9; p_valid held 1 and l_valid=1, l_addr=9, l_data=0xDEADBEEF, MAX_WAIT=4 → P granted cycles 0-3; L granted cycle 4 (p_ready=0); write of 0xDEADBEEF to 9 at cycle 5; busy_1 (chk_addr_1=9) falls at cycle 5; counter back to 0.
3. Scoreboard collision: busy[7]=1, L granted to 7 while issue_en=1, issue_addr=7 → busy[7] remains 1 next cycle; chk on 0 or issue_addr=0 → busy=0, no bit set.
4. Zero address: p_valid=1, p_addr=0, p_data=0xFFFFFFFF → p_ready=1; write_en=0 next cycle.
5. Reset mid-operation: busy[3]=1, counter=3, l_valid=1 with rst=1 for one cycle → after the edge busy=0, counter=0, write_en=0; ready outputs 0 during rst.
6. Back-to-back mix: alternating P (addr 1, 2) and L (addr 4) with no overlap → each grant writes exactly once, in order, one cycle after its grant, and write_en is never high without a preceding grant.
